// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: registered PC with branch/jump redirect, stall hold and a pending-target latch; PC_REDIRECT_COUNT_EN adds TAKEN_COUNT
module pc_redirect_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic        JUMP,
    input  logic [7:0]  OFFSET,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        REDIRECT,
    output logic        STALLED
`ifdef PC_REDIRECT_COUNT_EN
    ,
    output logic [15:0] TAKEN_COUNT
`endif
);
    typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;
    state_t      state, state_n;
    logic [31:0] pend, pend_n, pc_n, target;
    logic        req, redirect_n;
    assign PC_PLUS4 = PC + 32'd4;
    assign target   = PC_PLUS4 + {{22{OFFSET[7]}}, OFFSET, 2'b00};
    assign req      = BRANCH_TAKEN | JUMP;
    // next state: HOLD_PEND only waits for release; RUN and HOLD share the free-running/latching path
    always_comb begin
        state_n    = state;
        pc_n       = PC;
        pend_n     = pend;
        redirect_n = 1'b0;
        if (state == HOLD_PEND) begin
            if (!BUSYWAIT) begin
                pc_n       = pend;
                redirect_n = 1'b1;
                pend_n     = 32'd0;
                state_n    = RUN;
            end
        end else if (!BUSYWAIT) begin
            pc_n       = req ? target : PC_PLUS4;
            redirect_n = req;
            state_n    = RUN;
        end else if (req) begin
            pend_n  = target;
            state_n = HOLD_PEND;
        end else begin
            state_n = HOLD;
        end
    end
    // state, PC and status registers; reset discards any pending target
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= RUN;
            PC       <= 32'd0;
            pend     <= 32'd0;
            REDIRECT <= 1'b0;
            STALLED  <= 1'b0;
        end else begin
            state    <= state_n;
            PC       <= pc_n;
            pend     <= pend_n;
            REDIRECT <= redirect_n;
            STALLED  <= state_n != RUN;
        end
    end
`ifdef PC_REDIRECT_COUNT_EN
    // counts cycles in which PC is loaded with a redirect target
    always_ff @(posedge CLK) begin
        if (RESET) TAKEN_COUNT <= 16'd0;
        else       TAKEN_COUNT <= TAKEN_COUNT + {15'd0, redirect_n};
    end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vectors with hand-computed expectations for pc_redirect_unit
module tb_pc_redirect_unit;
    logic        CLK = 1'b0;
    logic        RESET, BUSYWAIT, BRANCH_TAKEN, JUMP;
    logic [7:0]  OFFSET;
    logic [31:0] PC, PC_PLUS4;
    logic        REDIRECT, STALLED;
    int          vecs = 0;
    int          errs = 0;
`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] TAKEN_COUNT;
`endif

    pc_redirect_unit dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .BRANCH_TAKEN(BRANCH_TAKEN),
        .JUMP(JUMP), .OFFSET(OFFSET), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .REDIRECT(REDIRECT), .STALLED(STALLED)
`ifdef PC_REDIRECT_COUNT_EN
        , .TAKEN_COUNT(TAKEN_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic rd, input logic st);
        chk({tag, ".pc"}, PC, pc);
        chk({tag, ".redirect"}, {31'd0, REDIRECT}, {31'd0, rd});
        chk({tag, ".stalled"}, {31'd0, STALLED}, {31'd0, st});
    endtask

    initial begin
        RESET = 1; BUSYWAIT = 0; BRANCH_TAKEN = 0; JUMP = 0; OFFSET = 8'h00;
        tick;
        chk_all("reset", 32'h0, 0, 0);
        chk("reset.pc_plus4", PC_PLUS4, 32'h4);
        RESET = 0;
        tick; chk_all("idle1", 32'h4, 0, 0);
        tick; chk_all("idle2", 32'h8, 0, 0);
        tick; tick; chk_all("idle4", 32'h10, 0, 0);
        BRANCH_TAKEN = 1; OFFSET = 8'hFE;
        tick; chk_all("br_back", 32'hC, 1, 0);
        BRANCH_TAKEN = 0;
        tick; chk_all("br_after", 32'h10, 0, 0);
        BRANCH_TAKEN = 1; JUMP = 1; OFFSET = 8'h03;
        tick; chk_all("br_and_jump", 32'h20, 1, 0);
        BRANCH_TAKEN = 0; BUSYWAIT = 1;
        tick; chk_all("stall1", 32'h20, 0, 1);
        OFFSET = 8'h7F;
        tick; chk_all("stall2", 32'h20, 0, 1);
        tick; chk_all("stall3", 32'h20, 0, 1);
        BUSYWAIT = 0; JUMP = 0; OFFSET = 8'h00;
        tick; chk_all("pend_release", 32'h30, 1, 0);
        tick; chk_all("pend_after", 32'h34, 0, 0);
        BUSYWAIT = 1;
        tick; chk_all("hold", 32'h34, 0, 1);
        BUSYWAIT = 0; BRANCH_TAKEN = 1;
        tick; chk_all("hold_release_off0", 32'h38, 1, 0);
        tick; chk_all("back_to_back", 32'h3C, 1, 0);
        BRANCH_TAKEN = 0;
        tick; chk_all("seq40", 32'h40, 0, 0);
        BUSYWAIT = 1; JUMP = 1; OFFSET = 8'h10;
        tick; chk_all("pend_before_reset", 32'h40, 0, 1);
        RESET = 1; JUMP = 0;
        tick; chk_all("reset_mid_stall", 32'h0, 0, 0);
        RESET = 0; BUSYWAIT = 0;
        tick; chk_all("no_pend_after_reset", 32'h4, 0, 0);
        BRANCH_TAKEN = 1; OFFSET = 8'hFD;
        tick; chk_all("to_top", 32'hFFFFFFFC, 1, 0);
        chk("top.pc_plus4", PC_PLUS4, 32'h0);
        BRANCH_TAKEN = 0;
        tick; chk_all("wrap", 32'h0, 0, 0);
        tick; chk_all("wrap_next", 32'h4, 0, 0);
        BRANCH_TAKEN = 1; OFFSET = 8'h80;
        tick; chk_all("neg_wrap", 32'hFFFFFE08, 1, 0);
        BRANCH_TAKEN = 0; JUMP = 1; BUSYWAIT = 1; OFFSET = 8'h00;
        tick; chk_all("pend2", 32'hFFFFFE08, 0, 1);
        OFFSET = 8'h05;
        tick; chk_all("ignored1", 32'hFFFFFE08, 0, 1);
        tick; chk_all("ignored2", 32'hFFFFFE08, 0, 1);
        BUSYWAIT = 0; JUMP = 0;
        tick; chk_all("pend2_release", 32'hFFFFFE0C, 1, 0);
        JUMP = 1; OFFSET = 8'h01;
        tick; chk_all("jump_a", 32'hFFFFFE14, 1, 0);
        tick; chk_all("jump_b", 32'hFFFFFE1C, 1, 0);
        JUMP = 0;
        tick; chk_all("final_seq", 32'hFFFFFE20, 0, 0);
`ifdef PC_REDIRECT_COUNT_EN
        chk("taken_count", {16'd0, TAKEN_COUNT}, 32'd5);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 The block SHALL expose these ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- BUSYWAIT  in  1  memory stall; PC must hold while high
- BRANCH_TAKEN  in  1  branch-taken decision from the beq/bne gates, OR-combined
- JUMP  in  1  unconditional jump request
- OFFSET  in  8  signed word offset of the current instruction
- PC  out  32  current instruction address, registered
- PC_PLUS4  out  32  PC+4, combinational from PC
- REDIRECT  out  1  registered pulse, high for the cycle after PC is loaded with a target
- STALLED  out  1  registered, high while state is HOLD or HOLD_PEND

REQ-002 Clocking and reset SHALL be one clock (CLK) and a synchronous, active-high reset (RESET).

Function
REQ-003 The redirect target SHALL be PC_PLUS4 + (sign_extend(OFFSET) << 2), computed modulo 2^32.
REQ-004 A redirect request SHALL be BRANCH_TAKEN | JUMP; both high together SHALL give one redirect to the same target.
REQ-005 The FSM SHALL have states RUN, HOLD and HOLD_PEND, and SHALL update on the rising CLK edge.
REQ-006 RUN, BUSYWAIT=0:
- PC SHALL load target if a request is present, else PC_PLUS4.
- REDIRECT SHALL be 1 next cycle only if a target was loaded.
REQ-007 RUN, BUSYWAIT=1:
- PC SHALL hold.
- With a request present: target latched into the pending register, next state HOLD_PEND.
- Otherwise: next state HOLD.
REQ-008 HOLD:
- BUSYWAIT=1: PC SHALL hold; a new request SHALL latch target and move to HOLD_PEND.
- BUSYWAIT=0: behave as RUN with BUSYWAIT=0 for that cycle, next state RUN.
REQ-009 HOLD_PEND:
- BUSYWAIT=1: PC SHALL hold; further requests SHALL be ignored (first latched target wins).
- BUSYWAIT=0: PC SHALL load the pending target, REDIRECT=1 next cycle, pending cleared, next state RUN; BRANCH_TAKEN/JUMP/OFFSET in that cycle SHALL be ignored.
REQ-010 Latency: PC change is visible one cycle after the qualifying edge; REDIRECT is never high for two consecutive cycles unless two consecutive redirects occur.
REQ-011 PC SHALL wrap from 0xFFFFFFFC to 0x00000000 with no error indication; a negative target below 0 SHALL also wrap modulo 2^32.
REQ-012 OFFSET=0 with a request SHALL load PC_PLUS4 and still assert REDIRECT.
REQ-013 The low two bits of PC SHALL always be 00.

Reset
REQ-014 RESET=1 at a clock edge SHALL set:
- PC=0x00000000, REDIRECT=0, STALLED=0
- state RUN, pending target=0
REQ-015 Reset SHALL take priority over all inputs, including mid-stall with a pending target, which SHALL be discarded.

Configuration
REQ-016 Macro PC_REDIRECT_COUNT_EN.
- Defined: add output TAKEN_COUNT (16 bits, registered, reset 0). It SHALL increment by 1 on every cycle PC loads a redirect target, wrap 0xFFFF->0x0000, and SHALL NOT count ignored or held requests.
- Undefined: no TAKEN_COUNT port and no counter logic; all other behaviour identical.

Verification
REQ-017 Reset, then 3 cycles idle -> PC=0x0, 0x4, 0x8; REDIRECT=0, STALLED=0.
REQ-018 PC=0x10, BRANCH_TAKEN=1, OFFSET=0xFE -> next PC=0x0C, REDIRECT=1 for one cycle.
REQ-019 PC=0x20, BUSYWAIT=1 for 3 cycles with JUMP=1, OFFSET=0x03 in the first stall cycle, then OFFSET=0x7F -> PC holds 0x20, STALLED=1; after release PC=0x30, REDIRECT=1.
REQ-020 PC=0x40 in HOLD_PEND, RESET=1 -> PC=0x0, STALLED=0, REDIRECT=0; no pending redirect taken after reset.
REQ-021 PC=0xFFFFFFFC, no request -> PC=0x00000000; PC=0x4, OFFSET=0x80, BRANCH_TAKEN=1 -> PC=0xFFFFFE08.
REQ-022 PC_REDIRECT_COUNT_EN defined: 5 taken redirects plus 2 requests ignored in HOLD_PEND -> TAKEN_COUNT=5.
